// File: rtl/victim_write_buffer.sv
// Single-entry victim/write-back buffer between cache_arbiter and physical memory.
// Define VICTIM_WRITE_BUFFER_STATS_EN to enable the saturating hit/drain counters.
module victim_write_buffer #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_read,
  input  logic              arb_write,
  input  logic [ADDR_W-1:0] arb_address,
  input  logic [LINE_W-1:0] arb_wdata,
  output logic [LINE_W-1:0] arb_rdata,
  output logic              arb_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [15:0]       hit_count,
  output logic [15:0]       drain_count
);
  localparam int TAG_W = ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {S_IDLE, S_MEM_READ, S_DRAIN, S_RESP, S_GAP} state_t;

  state_t            r_state;
  logic              r_buf_valid;
  logic [TAG_W-1:0]  r_buf_tag;
  logic [LINE_W-1:0] r_buf_data;
  logic [LINE_W-1:0] r_arb_rdata;
  logic              r_arb_resp;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_pmem_addr;
  logic [LINE_W-1:0] r_pmem_wdata;

  logic [TAG_W-1:0]  w_arb_tag;
  logic              w_hit;

  assign w_arb_tag = arb_address[ADDR_W-1:OFFSET_W];
  assign w_hit     = r_buf_valid && (r_buf_tag == w_arb_tag);

  assign arb_rdata    = r_arb_rdata;
  assign arb_resp     = r_arb_resp;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_addr;
  assign pmem_wdata   = r_pmem_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_buf_valid  <= 1'b0;
      r_buf_tag    <= '0;
      r_buf_data   <= '0;
      r_arb_rdata  <= '0;
      r_arb_resp   <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_pmem_addr  <= '0;
      r_pmem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arb_read) begin
            if (w_hit) begin
              r_arb_rdata <= r_buf_data;
              r_arb_resp  <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              // address is latched so pmem_* never depends combinationally on arb_*
              r_pmem_read <= 1'b1;
              r_pmem_addr <= arb_address;
              r_state     <= S_MEM_READ;
            end
          end else if (arb_write && !r_buf_valid) begin
            r_buf_tag   <= w_arb_tag;
            r_buf_data  <= arb_wdata;
            r_buf_valid <= 1'b1;
            r_arb_resp  <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_buf_valid) begin
            // full buffer (pending write or plain idle): drain first
            r_pmem_write <= 1'b1;
            r_pmem_addr  <= {r_buf_tag, {OFFSET_W{1'b0}}};
            r_pmem_wdata <= r_buf_data;
            r_state      <= S_DRAIN;
          end
        end
        S_MEM_READ: begin
          if (pmem_resp) begin
            r_pmem_read <= 1'b0;
            r_pmem_addr <= '0;
            r_arb_rdata <= pmem_rdata;
            r_arb_resp  <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_DRAIN: begin
          if (pmem_resp) begin
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
            r_buf_valid  <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_RESP: begin
          r_arb_resp <= 1'b0;
          r_state    <= S_GAP;
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VICTIM_WRITE_BUFFER_STATS_EN
  logic        w_hit_evt;
  logic        w_drain_evt;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_drain_cnt;

  assign w_hit_evt   = (r_state == S_IDLE) && arb_read && w_hit;
  assign w_drain_evt = (r_state == S_DRAIN) && pmem_resp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_hit_evt && (r_hit_cnt != 16'hFFFF))     r_hit_cnt   <= r_hit_cnt + 16'd1;
      if (w_drain_evt && (r_drain_cnt != 16'hFFFF)) r_drain_cnt <= r_drain_cnt + 16'd1;
    end
  end

  assign hit_count   = r_hit_cnt;
  assign drain_count = r_drain_cnt;
`else
  assign hit_count   = 16'd0;
  assign drain_count = 16'd0;
`endif

endmodule

// File: tb/tb_victim_write_buffer.sv
// Bench for victim_write_buffer: vector table, reset-mid-drain sequence, random vs. line-level model.
module tb_victim_write_buffer;
`ifdef VICTIM_WRITE_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         arb_read = 1'b0, arb_write = 1'b0;
  logic [15:0]  arb_address = '0;
  logic [127:0] arb_wdata = '0;
  logic [127:0] arb_rdata;
  logic         arb_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [15:0]  hit_count, drain_count;

  victim_write_buffer dut (
    .clk(clk), .reset(reset),
    .arb_read(arb_read), .arb_write(arb_write), .arb_address(arb_address),
    .arb_wdata(arb_wdata), .arb_rdata(arb_rdata), .arb_resp(arb_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .drain_count(drain_count)
  );

  always #5 clk = ~clk;

  typedef struct {bit wr; logic [15:0] addr;} op_t;
  op_t          oplog[$];
  logic [127:0] mem [logic [11:0]];
  int total = 0, bad = 0, excl_bad = 0, pcnt = 0, plat = 2;

  function automatic logic [127:0] line_pat(input logic [11:0] line);
    return {8{line, 4'hC}} ^ {4{32'hDEADBEEF}};
  endfunction

  function automatic logic [127:0] mem_rd(input logic [11:0] line);
    if (mem.exists(line)) return mem[line];
    return line_pat(line);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // pmem model: responds plat cycles after a strobe rises, one-cycle resp pulse
  always @(negedge clk) begin
    if (pmem_read && pmem_write) excl_bad++;
    if (reset) begin
      pcnt = 0;
      pmem_resp = 1'b0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
    end else if (pmem_read || pmem_write) begin
      pcnt++;
      if (pcnt >= plat) begin
        pcnt = 0;
        pmem_resp = 1'b1;
        if (pmem_write) mem[pmem_address[15:4]] = pmem_wdata;
        else            pmem_rdata = mem_rd(pmem_address[15:4]);
        oplog.push_back('{pmem_write, pmem_address});
      end
    end
  end

  task automatic apply_reset();
    arb_read = 1'b0; arb_write = 1'b0;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // lat: cycle in which arb_resp is seen, counting the request-raise cycle as 1
  task automatic do_req(input bit rd, input logic [15:0] addr, input logic [127:0] wd,
                        output logic [127:0] rdata, output int lat, output int nrd,
                        output int nwr, output logic [15:0] first);
    int  base = oplog.size();
    bit  got = 1'b0;
    arb_read = rd; arb_write = !rd; arb_address = addr; arb_wdata = wd;
    lat = 1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (arb_resp) begin got = 1'b1; break; end
    end
    chk("resp_seen", 128'(got), 128'(1));
    rdata = arb_rdata;
    nrd = 0; nwr = 0;
    for (int k = base; k < oplog.size(); k++) if (oplog[k].wr) nwr++; else nrd++;
    first = (oplog.size() > base) ? oplog[base].addr : 16'h0;
    arb_read = 1'b0; arb_write = 1'b0;
    @(negedge clk);
    chk("resp_one_cycle", 128'(arb_resp), 128'(0));
  endtask

  typedef struct {
    bit rd; logic [15:0] addr; logic [127:0] wdata; int gap;
    logic [127:0] exp_rdata; int exp_lat; int exp_nrd; int exp_nwr; logic [15:0] exp_first;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[11];
    logic [127:0] d1, d2, d3, d4, d5, rdat;
    logic [15:0]  first;
    int           lat, nrd, nwr, wseen, base;
    bit           got;
    bit           mv;
    logic [11:0]  mtag, line;
    int           mhit, mdrain, gap, offc, exp_l;
    bit           rd, hit;
    logic [127:0] wd, exp_d;
    logic [127:0] shadow [logic [11:0]];

    d1 = {4{32'h11111111}}; d2 = {4{32'h22222222}}; d3 = {4{32'h33333333}};
    d4 = {4{32'h44444444}}; d5 = {4{32'h55555555}};
    // pmem latency 2 throughout the table
    vt[0]  = '{0, 16'h1230, d1, 0, '0, 2, 0, 0, 16'h0};
    vt[1]  = '{1, 16'h1238, '0, 0, d1, 3, 0, 0, 16'h0};
    vt[2]  = '{1, 16'h4560, '0, 0, line_pat(12'h456), 5, 1, 0, 16'h4560};
    vt[3]  = '{0, 16'h7770, d2, 0, '0, 6, 0, 1, 16'h1230};
    vt[4]  = '{1, 16'h1230, '0, 5, d1, 4, 1, 0, 16'h1230};
    vt[5]  = '{0, 16'h1230, d3, 3, '0, 2, 0, 0, 16'h0};
    vt[6]  = '{0, 16'h2220, d4, 0, '0, 6, 0, 1, 16'h1230};
    vt[7]  = '{1, 16'h2220, '0, 0, d4, 3, 0, 0, 16'h0};
    vt[8]  = '{1, 16'h222F, '0, 0, d4, 3, 0, 0, 16'h0};
    vt[9]  = '{1, 16'h2230, '0, 0, line_pat(12'h223), 5, 1, 0, 16'h2230};
    vt[10] = '{1, 16'h7770, '0, 0, d2, 5, 1, 0, 16'h7770};

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_arb_resp", 128'(arb_resp), 128'(0));
    chk("rst_arb_rdata", arb_rdata, '0);
    chk("rst_pmem_strobes", 128'({pmem_read, pmem_write}), 128'(0));
    chk("rst_pmem_addr", 128'(pmem_address), 128'(0));
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_counters", 128'({hit_count, drain_count}), 128'(0));
    reset = 1'b0;
    plat = 2; mem.delete(); oplog.delete();

    for (int i = 0; i < 11; i++) begin
      repeat (vt[i].gap) @(negedge clk);
      do_req(vt[i].rd, vt[i].addr, vt[i].wdata, rdat, lat, nrd, nwr, first);
      if (vt[i].rd) chk($sformatf("vec%0d_rdata", i), rdat, vt[i].exp_rdata);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(vt[i].exp_lat));
      chk($sformatf("vec%0d_nrd", i), 128'(nrd), 128'(vt[i].exp_nrd));
      chk($sformatf("vec%0d_nwr", i), 128'(nwr), 128'(vt[i].exp_nwr));
      if (nrd + nwr > 0) chk($sformatf("vec%0d_first_addr", i), 128'(first), 128'(vt[i].exp_first));
    end
    chk("tbl_hit_count", 128'(hit_count), 128'(STATS ? 3 : 0));
    chk("tbl_drain_count", 128'(drain_count), 128'(STATS ? 3 : 0));

    // reset in the middle of a 3-cycle drain
    apply_reset(); mem.delete(); oplog.delete(); plat = 3;
    do_req(0, 16'h5550, d5, rdat, lat, nrd, nwr, first);
    chk("rd_write_lat", 128'(lat), 128'(2));
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pmem_write) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("rd_drain_started", 128'(got), 128'(1));
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rd_pmem_write", 128'(pmem_write), 128'(0));
    chk("rd_pmem_read", 128'(pmem_read), 128'(0));
    chk("rd_pmem_addr", 128'(pmem_address), 128'(0));
    chk("rd_pmem_wdata", pmem_wdata, '0);
    chk("rd_arb_out", {arb_rdata[126:0], arb_resp}, '0);
    chk("rd_counters", 128'({hit_count, drain_count}), 128'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    base = oplog.size(); wseen = 0;
    repeat (10) begin @(negedge clk); if (pmem_write) wseen++; end
    chk("rd_no_write_cycles", 128'(wseen), 128'(0));
    chk("rd_no_write_ops", 128'(oplog.size() - base), 128'(0));
    do_req(1, 16'h5550, '0, rdat, lat, nrd, nwr, first);
    chk("rd_line_lost", rdat, line_pat(12'h555));
    chk("rd_line_miss", 128'(nrd), 128'(1));

    // random traffic against a line-level model
    apply_reset(); mem.delete(); oplog.delete();
    plat = $urandom_range(1, 4);
    mv = 1'b0; mtag = '0; mhit = 0; mdrain = 0;
    for (int n = 0; n < 150; n++) begin
      rd   = 1'($urandom_range(0, 1));
      line = 12'h100 + 12'($urandom_range(0, 3));
      gap  = $urandom_range(0, 3);
      wd   = {$urandom, $urandom, $urandom, $urandom};
      // a buffered line survives only if IDLE sees a request on its first cycle
      if (gap >= 2 && mv) begin mv = 1'b0; mdrain++; end
      offc = (gap == 0) ? 1 : 0;
      exp_d = '0;
      if (rd) begin
        hit = mv && (mtag == line);
        if (hit) mhit++;
        exp_d = shadow.exists(line) ? shadow[line] : line_pat(line);
        exp_l = hit ? 2 + offc : plat + 2 + offc;
      end else begin
        if (mv) begin mdrain++; exp_l = plat + 3 + offc; end
        else exp_l = 2 + offc;
        mv = 1'b1; mtag = line; shadow[line] = wd;
      end
      repeat (gap) @(negedge clk);
      do_req(rd, {line, 4'($urandom_range(0, 15))}, wd, rdat, lat, nrd, nwr, first);
      if (rd) chk($sformatf("rnd%0d_rdata", n), rdat, exp_d);
      if (gap <= 1) chk($sformatf("rnd%0d_lat", n), 128'(lat), 128'(exp_l));
    end
    repeat (plat + 8) @(negedge clk);
    if (mv) mdrain++;
    chk("rnd_hit_count", 128'(hit_count), 128'(STATS ? mhit : 0));
    chk("rnd_drain_count", 128'(drain_count), 128'(STATS ? mdrain : 0));
    foreach (shadow[k]) chk($sformatf("rnd_mem_%h", k), mem_rd(k), shadow[k]);
    chk("pmem_strobe_exclusive", 128'(excl_bad), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
